axis_fifo_slice_m: RTL and testbench
====================================

// Module: axis_fifo_slice_m
// PURPOSE
//  Parametrised AXI4-Stream buffer: successor to the single-entry register slice. DEPTH-entry circular
//  buffer; TREADY and TVALID fully registered; carries TUSER/TID; optional packet mode.
//  Inserted between stream producers and consumers for timing closure and rate decoupling.
// PARAMETERS
//  DATA_W       64   TDATA width, multiple of 8; KEEP_W = DATA_W/8
//  USER_W       1    TUSER width (>=1)
//  ID_W         1    TID width (>=1)
//  DEPTH        4    entries; power of 2, >=2
//  AFULL_THR    3    almost_full asserted when count >= AFULL_THR (1..DEPTH)
//  PKT_MODE     0    0: cut-through; 1: output held until a complete packet (TLAST) is stored
//  CNT_W        $clog2(DEPTH+1) (localparam) count width
// PORTS
//  ACLK          in   1        clock, all logic on rising edge
//  ARESETn       in   1        asynchronous active-low reset
//  flush         in   1        sync clear of all stored beats
//  s_tvalid      in   1        input beat valid
//  s_tready      out  1        input ready (registered)
//  s_tdata       in   DATA_W   input data
//  s_tkeep       in   KEEP_W   input byte keep
//  s_tuser       in   USER_W   input sideband
//  s_tid         in   ID_W     input stream id
//  s_tlast       in   1        input end of packet
//  m_tvalid      out  1        output beat valid (registered)
//  m_tready      in   1        output ready
//  m_tdata/m_tkeep/m_tuser/m_tid/m_tlast  out  as s_*  output beat (registered)
//  count         out  CNT_W    stored beats
//  almost_full   out  1        count >= AFULL_THR
//  pkt_count     out  CNT_W    complete packets stored (TLAST beats in buffer)
// BEHAVIOUR
//  - Reset (ARESETn low, async): count=0, pkt_count=0, pointers=0, m_tvalid=0, s_tready=0,
//    almost_full=0, m_t* data outputs=0. s_tready rises on first ACLK edge after release.
//  - push = s_tvalid & s_tready; pop = m_tvalid & m_tready. count(n+1) = count + push - pop.
//  - s_tready registered: next = (count_next < DEPTH) & !flush. Never depends on m_tready
//    combinationally. Data presented while s_tready=0 is ignored; producer holds per AXI.
//  - Latency: beat pushed into empty buffer at edge N appears on m_* after edge N (visible in
//    cycle N+1); 1-cycle latency. Sustained 1 beat/clk when both sides ready, DEPTH>=2.
//  - m_* outputs are the head entry, registered; stable while m_tvalid & !m_tready (AXI rule).
//  - Simultaneous push+pop: count unchanged, both pointers advance; legal at count=DEPTH-1 and 1.
//  - Full (count=DEPTH): s_tready=0; pop frees slot, s_tready=1 next cycle.
//  - Empty: m_tvalid=0; simultaneous push into empty goes to head register directly.
//  - Pointers wrap modulo DEPTH; no wrap bubble.
//  - pkt_count: +1 on push with s_tlast, -1 on pop with m_tlast, net 0 if both.
//  - PKT_MODE=0: m_tvalid = (count != 0).
//    PKT_MODE=1: m_tvalid = (pkt_count != 0) | (count == DEPTH) (full release prevents deadlock on
//    packets longer than DEPTH); once a beat is presented, m_tvalid stays high until it is popped.
//  - flush (sync, highest priority): at next edge count=0, pkt_count=0, pointers=0, m_tvalid=0,
//    s_tready=0 for that cycle, 1 thereafter; push/pop in flush cycle are discarded.
//  - Reset mid-transfer: all stored beats lost, outputs to reset values immediately.
//  - Invariants: 0<=count<=DEPTH; pkt_count<=count; no m_* change while stalled.
// TESTING
//  1 DEPTH=4, stream 0..15 with m_tready=1 -> output 0..15 in order, one beat/clk, latency 1,
//    count<=1.
//  2 m_tready=0, push 5 beats -> 4 accepted, s_tready=0 after 4th, count=4, almost_full=1 at 3;
//    release -> 4 beats out in order, s_tready back to 1 one cycle after first pop.
//  3 Random s_tvalid/m_tready (50%), 1000 beats with TUSER/TID/TKEEP -> scoreboard match, AXI
//    stability assertions hold, count never >4.
//  4 PKT_MODE=1: push 3-beat packet slowly, m_tready=1 -> m_tvalid=0 until TLAST stored, then
//    3 beats back-to-back; 6-beat packet with DEPTH=4 -> released at count=4, no deadlock.
//  5 flush with count=3 and simultaneous push -> next cycle count=0, m_tvalid=0, pushed beat absent;
//    following beat emerges normally.
//  6 ARESETn asserted mid-burst (async, between edges) -> m_tvalid, s_tready drop immediately;
//    after release first new beat out unaltered, no stale data.

Source files
------------

// File: rtl/axis_fifo_slice_m.sv
// ---------------------------------------------------------------------------
// axis_fifo_slice_m
//
// AXI4-Stream buffer of DEPTH entries. It replaces the single-entry register
// slice and carries TKEEP, TUSER, TID and TLAST with the data. Both handshake
// outputs come straight from flops: s_tready never depends on m_tready
// within the same cycle. The m_* beat is the head entry, held in its own
// output register. Use it between a producer and a consumer to break timing
// paths and to absorb rate differences.
//
// With PKT_MODE=1 the output holds back until a complete packet (a TLAST
// beat) is stored. A completely full buffer is also released, so a packet
// longer than DEPTH cannot deadlock.
//
// Ports
//   ACLK, ARESETn     clock (rising edge) / asynchronous active-low reset
//   flush             synchronous clear of every stored beat; overrides push/pop
//   s_tvalid/s_tready input handshake (s_tready registered)
//   s_tdata/s_tkeep/s_tuser/s_tid/s_tlast   input beat
//   m_tvalid/m_tready output handshake (m_tvalid registered)
//   m_tdata/m_tkeep/m_tuser/m_tid/m_tlast   output beat (registered head)
//   count             stored beats, including the one on m_*
//   almost_full       count >= AFULL_THR
//   pkt_count         stored beats that carry TLAST
// ---------------------------------------------------------------------------
module axis_fifo_slice_m #(
   parameter  int DATA_W    = 64,
   parameter  int USER_W    = 1,
   parameter  int ID_W      = 1,
   parameter  int DEPTH     = 4,
   parameter  int AFULL_THR = 3,
   parameter  int PKT_MODE  = 0,
   localparam int KEEP_W    = DATA_W / 8,
   localparam int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic              flush,
   input  logic              s_tvalid,
   output logic              s_tready,
   input  logic [DATA_W-1:0] s_tdata,
   input  logic [KEEP_W-1:0] s_tkeep,
   input  logic [USER_W-1:0] s_tuser,
   input  logic [ID_W-1:0]   s_tid,
   input  logic              s_tlast,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic [DATA_W-1:0] m_tdata,
   output logic [KEEP_W-1:0] m_tkeep,
   output logic [USER_W-1:0] m_tuser,
   output logic [ID_W-1:0]   m_tid,
   output logic              m_tlast,
   output logic [CNT_W-1:0]  count,
   output logic              almost_full,
   output logic [CNT_W-1:0]  pkt_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [KEEP_W-1:0] keep;
      logic [USER_W-1:0] user;
      logic [ID_W-1:0]   id;
      logic              last;
   } beat_t;

   // Storage and state
   beat_t            r_mem [DEPTH];
   beat_t            r_head;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_pkt_count;
   logic             r_s_tready;
   logic             r_m_tvalid;
   logic             r_almost_full;

   // Next-state values
   beat_t            w_s_beat;
   beat_t            w_head_nxt;
   logic             w_push;
   logic             w_pop;
   logic             w_bypass;
   logic             w_s_tready_nxt;
   logic             w_m_tvalid_nxt;
   logic [PTR_W-1:0] w_wr_ptr_nxt;
   logic [PTR_W-1:0] w_rd_ptr_nxt;
   logic [CNT_W-1:0] w_count_after_pop;
   logic [CNT_W-1:0] w_count_nxt;
   logic [CNT_W-1:0] w_pkt_count_nxt;

   assign w_s_beat = {s_tdata, s_tkeep, s_tuser, s_tid, s_tlast};
   assign w_push   = s_tvalid & r_s_tready;
   assign w_pop    = r_m_tvalid & m_tready;

   // NOTE: every signal in this block gets a value on every path before any
   // condition is evaluated. A path that left one unassigned would infer a latch.
   always_comb begin
      w_count_after_pop = r_count - CNT_W'(w_pop);
      w_count_nxt       = w_count_after_pop + CNT_W'(w_push);
      w_pkt_count_nxt   = r_pkt_count + CNT_W'(w_push & s_tlast)
                                      - CNT_W'(w_pop & r_head.last);
      w_wr_ptr_nxt      = r_wr_ptr + PTR_W'(w_push);
      w_rd_ptr_nxt      = r_rd_ptr + PTR_W'(w_pop);
      // If the buffer would be empty after this pop, the incoming beat is the
      // new head. Its memory slot is written on the same edge, so it cannot be
      // read back yet; take it straight from the input instead.
      w_bypass          = w_push & (w_count_after_pop == '0);
      w_head_nxt        = w_bypass ? w_s_beat : r_mem[w_rd_ptr_nxt];
      w_s_tready_nxt    = (w_count_nxt < CNT_W'(DEPTH));
      w_m_tvalid_nxt    = (w_count_nxt != '0);
      if (PKT_MODE != 0) begin
         // A beat already on the output stays valid until it is taken.
         // A full buffer is released even without TLAST, so an over-long
         // packet can still drain.
         w_m_tvalid_nxt = (r_m_tvalid & ~m_tready)
                        | (w_pkt_count_nxt != '0)
                        | (w_count_nxt == CNT_W'(DEPTH));
      end
   end

   // NOTE: the data array has no reset. Its contents are never visible until
   // a slot is written, because count and the pointers are reset. Leaving it
   // off the reset net lets synthesis map it to plain registers or RAM.
   always_ff @(posedge ACLK) begin
      if (w_push & ~flush) begin
         r_mem[r_wr_ptr] <= w_s_beat;
      end
   end

   // NOTE: every register here is assigned with <=. All of them sample the
   // values from before the edge, so the order of the statements does not matter.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_head        <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_pkt_count   <= '0;
         r_s_tready    <= 1'b0;
         r_m_tvalid    <= 1'b0;
         r_almost_full <= 1'b0;
      end else if (flush) begin
         // Push and pop in this cycle are dropped; input stays closed for one cycle.
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_pkt_count   <= '0;
         r_s_tready    <= 1'b0;
         r_m_tvalid    <= 1'b0;
         r_almost_full <= 1'b0;
      end else begin
         r_wr_ptr      <= w_wr_ptr_nxt;
         r_rd_ptr      <= w_rd_ptr_nxt;
         r_count       <= w_count_nxt;
         r_pkt_count   <= w_pkt_count_nxt;
         r_s_tready    <= w_s_tready_nxt;
         r_m_tvalid    <= w_m_tvalid_nxt;
         r_almost_full <= (w_count_nxt >= CNT_W'(AFULL_THR));
         // When empty, the output register simply keeps its last value.
         if (w_count_nxt != '0) begin
            r_head <= w_head_nxt;
         end
      end
   end

   assign s_tready    = r_s_tready;
   assign m_tvalid    = r_m_tvalid;
   assign m_tdata     = r_head.data;
   assign m_tkeep     = r_head.keep;
   assign m_tuser     = r_head.user;
   assign m_tid       = r_head.id;
   assign m_tlast     = r_head.last;
   assign count       = r_count;
   assign almost_full = r_almost_full;
   assign pkt_count   = r_pkt_count;

endmodule

// File: tb/tb_axis_fifo_slice_m.sv
// ---------------------------------------------------------------------------
// tb_axis_fifo_slice_m
//
// Directed bench for axis_fifo_slice_m. There are two instances:
//   u_dut  - default parameters, cut-through mode
//   u_pkt  - PKT_MODE=1; it shares the s_* payload inputs with u_dut but has
//            its own handshakes
// Inputs change on the falling edge. Outputs are read on the falling edge,
// so a handshake seen there takes effect on the next rising edge.
// ---------------------------------------------------------------------------
module tb_axis_fifo_slice_m;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        user;
      logic        id;
      logic        last;
   } beat_t;

   logic        ACLK = 1'b0;
   logic        ARESETn;
   logic        flush;
   logic        s_tvalid, s_tready;
   logic [63:0] s_tdata;
   logic [7:0]  s_tkeep;
   logic        s_tuser, s_tid, s_tlast;
   logic        m_tvalid, m_tready;
   logic [63:0] m_tdata;
   logic [7:0]  m_tkeep;
   logic        m_tuser, m_tid, m_tlast;
   logic [2:0]  count, pkt_count;
   logic        almost_full;

   logic        p_flush;
   logic        p_s_tvalid, p_s_tready;
   logic        p_m_tvalid, p_m_tready;
   logic [63:0] p_m_tdata;
   logic [7:0]  p_m_tkeep;
   logic        p_m_tuser, p_m_tid, p_m_tlast;
   logic [2:0]  p_count, p_pkt_count;
   logic        p_almost_full;

   int errors = 0;
   int checks = 0;

   always #5 ACLK = ~ACLK;

   axis_fifo_slice_m u_dut (
      .ACLK(ACLK), .ARESETn(ARESETn), .flush(flush),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
      .s_tuser(s_tuser), .s_tid(s_tid), .s_tlast(s_tlast),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
      .m_tuser(m_tuser), .m_tid(m_tid), .m_tlast(m_tlast),
      .count(count), .almost_full(almost_full), .pkt_count(pkt_count)
   );

   axis_fifo_slice_m #(.PKT_MODE(1)) u_pkt (
      .ACLK(ACLK), .ARESETn(ARESETn), .flush(p_flush),
      .s_tvalid(p_s_tvalid), .s_tready(p_s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
      .s_tuser(s_tuser), .s_tid(s_tid), .s_tlast(s_tlast),
      .m_tvalid(p_m_tvalid), .m_tready(p_m_tready), .m_tdata(p_m_tdata), .m_tkeep(p_m_tkeep),
      .m_tuser(p_m_tuser), .m_tid(p_m_tid), .m_tlast(p_m_tlast),
      .count(p_count), .almost_full(p_almost_full), .pkt_count(p_pkt_count)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic test_reset();
      #10;
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid: got %b exp 0", m_tvalid); end
      checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_s_tready: got %b exp 0", s_tready); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d exp 0", count); end
      checks++; if (pkt_count !== 3'd0) begin errors++; $display("FAIL rst_pkt_count: got %0d exp 0", pkt_count); end
      checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL rst_afull: got %b exp 0", almost_full); end
      checks++; if ({m_tdata, m_tkeep, m_tuser, m_tid, m_tlast} !== 75'd0) begin
         errors++; $display("FAIL rst_m_data: got %h exp 0", {m_tdata, m_tkeep, m_tuser, m_tid, m_tlast}); end
      @(negedge ACLK);
      ARESETn = 1'b1;
      checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_release_ready: got %b exp 0", s_tready); end
      @(negedge ACLK);
      checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL rst_first_edge_ready: got %b exp 1", s_tready); end
      checks++; if (p_s_tready !== 1'b1) begin errors++; $display("FAIL rst_pkt_ready: got %b exp 1", p_s_tready); end
   endtask

   task automatic test_stream();
      m_tready = 1'b1;
      for (int i = 0; i <= 16; i++) begin
         s_tvalid = (i < 16);
         s_tdata  = 64'(i);
         checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b exp 1", i, s_tready); end
         checks++; if (m_tvalid !== (i > 0)) begin errors++; $display("FAIL stream_valid[%0d]: got %b exp %b", i, m_tvalid, i > 0); end
         checks++; if (count !== 3'(i > 0)) begin errors++; $display("FAIL stream_count[%0d]: got %0d exp %0d", i, count, i > 0); end
         if (i > 0) begin
            checks++; if (m_tdata !== 64'(i - 1)) begin errors++; $display("FAIL stream_data[%0d]: got %0d exp %0d", i, m_tdata, i - 1); end
         end
         @(negedge ACLK);
      end
      s_tvalid = 1'b0;
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL stream_drained: got %b exp 0", m_tvalid); end
   endtask

   task automatic test_full();
      int n;
      int exp_cnt [6] = '{4, 3, 3, 2, 1, 0};
      m_tready = 1'b0;
      for (int j = 0; j <= 5; j++) begin
         n = (j < 4) ? j : 4;
         s_tvalid = 1'b1;
         s_tdata  = 64'(100 + n);
         checks++; if (count !== 3'(n)) begin errors++; $display("FAIL full_count[%0d]: got %0d exp %0d", j, count, n); end
         checks++; if (s_tready !== (j < 4)) begin errors++; $display("FAIL full_ready[%0d]: got %b exp %b", j, s_tready, j < 4); end
         checks++; if (almost_full !== (j >= 3)) begin errors++; $display("FAIL full_afull[%0d]: got %b exp %b", j, almost_full, j >= 3); end
         @(negedge ACLK);
      end
      m_tready = 1'b1;
      for (int k = 0; k <= 5; k++) begin
         s_tvalid = (k <= 1);
         s_tdata  = 64'd104;
         checks++; if (m_tvalid !== (k <= 4)) begin errors++; $display("FAIL drain_valid[%0d]: got %b exp %b", k, m_tvalid, k <= 4); end
         checks++; if (s_tready !== (k >= 1)) begin errors++; $display("FAIL drain_ready[%0d]: got %b exp %b", k, s_tready, k >= 1); end
         checks++; if (count !== 3'(exp_cnt[k])) begin errors++; $display("FAIL drain_count[%0d]: got %0d exp %0d", k, count, exp_cnt[k]); end
         if (k <= 4) begin
            checks++; if (m_tdata !== 64'(100 + k)) begin errors++; $display("FAIL drain_data[%0d]: got %0d exp %0d", k, m_tdata, 100 + k); end
         end
         @(negedge ACLK);
      end
      s_tvalid = 1'b0;
   endtask

   task automatic test_flush();
      m_tready = 1'b0;
      s_tlast  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         s_tvalid = 1'b1;
         s_tdata  = 64'(200 + i);
         @(negedge ACLK);
      end
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d exp 3", count); end
      checks++; if (pkt_count !== 3'd3) begin errors++; $display("FAIL flush_pre_pkt: got %0d exp 3", pkt_count); end
      flush   = 1'b1;
      s_tdata = 64'hDEAD;
      @(negedge ACLK);
      flush    = 1'b0;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d exp 0", count); end
      checks++; if (pkt_count !== 3'd0) begin errors++; $display("FAIL flush_pkt: got %0d exp 0", pkt_count); end
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b exp 0", m_tvalid); end
      checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL flush_ready_low: got %b exp 0", s_tready); end
      @(negedge ACLK);
      checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL flush_ready_back: got %b exp 1", s_tready); end
      m_tready = 1'b1;
      s_tvalid = 1'b1;
      s_tdata  = 64'hBEEF;
      @(negedge ACLK);
      s_tvalid = 1'b0;
      checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL flush_next_valid: got %b exp 1", m_tvalid); end
      checks++; if (m_tdata !== 64'hBEEF) begin errors++; $display("FAIL flush_next_data: got %h exp beef", m_tdata); end
      @(negedge ACLK);
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL flush_no_stale: got %b exp 0", m_tvalid); end
   endtask

   task automatic test_random();
      beat_t q[$];
      beat_t cur, exp_b, out_b, prev_out;
      logic  hold = 1'b0;
      logic  prev_stall = 1'b0;
      int    sent = 0, rcvd = 0, cyc = 0, n_last = 0;
      cur = '0;
      prev_out = '0;
      while (rcvd < 1000 && cyc < 20000) begin
         if (!hold && sent < 1000 && $urandom_range(0, 1) == 1) begin
            cur  = {$urandom, $urandom, 8'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0)};
            hold = 1'b1;
         end
         s_tvalid = hold;
         {s_tdata, s_tkeep, s_tuser, s_tid, s_tlast} = cur;
         m_tready = 1'($urandom_range(0, 1));
         out_b = {m_tdata, m_tkeep, m_tuser, m_tid, m_tlast};
         checks++; if (count !== 3'(q.size())) begin errors++; $display("FAIL rnd_count@%0d: got %0d exp %0d", cyc, count, q.size()); end
         checks++; if (pkt_count !== 3'(n_last)) begin errors++; $display("FAIL rnd_pkt@%0d: got %0d exp %0d", cyc, pkt_count, n_last); end
         checks++; if (almost_full !== (q.size() >= 3)) begin errors++; $display("FAIL rnd_afull@%0d: got %b exp %b", cyc, almost_full, q.size() >= 3); end
         if (prev_stall) begin
            checks++; if (m_tvalid !== 1'b1 || out_b !== prev_out) begin
               errors++; $display("FAIL rnd_stable@%0d: got %b/%h exp 1/%h", cyc, m_tvalid, out_b, prev_out); end
         end
         if (m_tvalid && m_tready) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL rnd_pop_empty@%0d: got valid 1 exp 0", cyc);
            end else begin
               exp_b = q.pop_front();
               if (exp_b.last) n_last--;
               if (out_b !== exp_b) begin errors++; $display("FAIL rnd_beat[%0d]: got %h exp %h", rcvd, out_b, exp_b); end
            end
            rcvd++;
         end
         if (s_tvalid && s_tready) begin
            q.push_back(cur);
            if (cur.last) n_last++;
            sent++;
            hold = 1'b0;
         end
         prev_stall = m_tvalid & ~m_tready;
         prev_out   = out_b;
         @(negedge ACLK);
         cyc++;
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      m_tready = 1'b1;
      checks++; if (rcvd != 1000) begin errors++; $display("FAIL rnd_timeout: got %0d beats exp 1000", rcvd); end
      @(negedge ACLK);
   endtask

   task automatic test_pkt();
      int sent = 0, rcvd = 0, cyc = 0;
      p_m_tready = 1'b1;
      s_tkeep = 8'hFF; s_tuser = 1'b0; s_tid = 1'b0;
      for (int c = 0; c <= 4; c++) begin
         p_s_tvalid = (c % 2 == 0);
         s_tdata    = 64'(300 + c / 2);
         s_tlast    = (c == 4);
         checks++; if (p_m_tvalid !== 1'b0) begin errors++; $display("FAIL pkt_hold[%0d]: got %b exp 0", c, p_m_tvalid); end
         @(negedge ACLK);
      end
      p_s_tvalid = 1'b0;
      s_tlast    = 1'b0;
      checks++; if (p_pkt_count !== 3'd1) begin errors++; $display("FAIL pkt_count_one: got %0d exp 1", p_pkt_count); end
      for (int c = 0; c < 3; c++) begin
         checks++; if (p_m_tvalid !== 1'b1) begin errors++; $display("FAIL pkt_b2b_valid[%0d]: got %b exp 1", c, p_m_tvalid); end
         checks++; if ({p_m_tdata, p_m_tlast} !== {64'(300 + c), c == 2}) begin
            errors++; $display("FAIL pkt_b2b_beat[%0d]: got %0d/%b exp %0d/%b", c, p_m_tdata, p_m_tlast, 300 + c, c == 2); end
         @(negedge ACLK);
      end
      checks++; if (p_m_tvalid !== 1'b0 || p_count !== 3'd0) begin
         errors++; $display("FAIL pkt_empty: got %b/%0d exp 0/0", p_m_tvalid, p_count); end
      // Six-beat packet through a four-entry buffer
      while (rcvd < 6 && cyc < 60) begin
         p_s_tvalid = (sent < 6);
         s_tdata    = 64'(400 + sent);
         s_tlast    = (sent == 5);
         if (p_m_tvalid && rcvd == 0) begin
            checks++; if (p_count !== 3'd4) begin errors++; $display("FAIL pkt_full_release: got count %0d exp 4", p_count); end
         end
         if (p_m_tvalid) begin
            checks++; if ({p_m_tdata, p_m_tlast} !== {64'(400 + rcvd), rcvd == 5}) begin
               errors++; $display("FAIL pkt_long_beat[%0d]: got %0d/%b exp %0d/%b", rcvd, p_m_tdata, p_m_tlast, 400 + rcvd, rcvd == 5); end
            rcvd++;
         end
         if (p_s_tvalid && p_s_tready) sent++;
         @(negedge ACLK);
         cyc++;
      end
      p_s_tvalid = 1'b0;
      s_tlast    = 1'b0;
      checks++; if (rcvd != 6) begin errors++; $display("FAIL pkt_deadlock: got %0d beats exp 6", rcvd); end
   endtask

   task automatic test_reset_mid();
      m_tready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         s_tvalid = 1'b1;
         s_tdata  = 64'(500 + i);
         @(negedge ACLK);
      end
      checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b exp 1", m_tvalid); end
      #2 ARESETn = 1'b0;
      #1;
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL mid_valid_drop: got %b exp 0", m_tvalid); end
      checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL mid_ready_drop: got %b exp 0", s_tready); end
      checks++; if (count !== 3'd0 || m_tdata !== 64'd0) begin
         errors++; $display("FAIL mid_state_clear: got %0d/%h exp 0/0", count, m_tdata); end
      s_tvalid = 1'b0;
      @(negedge ACLK);
      ARESETn = 1'b1;
      @(negedge ACLK);
      checks++; if (s_tready !== 1'b1 || m_tvalid !== 1'b0) begin
         errors++; $display("FAIL mid_after_release: got ready %b valid %b exp 1/0", s_tready, m_tvalid); end
      s_tvalid = 1'b1;
      {s_tdata, s_tkeep, s_tuser, s_tid, s_tlast} = {64'h0123_4567_89AB_600D, 8'hA5, 1'b1, 1'b1, 1'b1};
      @(negedge ACLK);
      s_tvalid = 1'b0;
      checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL mid_new_valid: got %b exp 1", m_tvalid); end
      checks++; if ({m_tdata, m_tkeep, m_tuser, m_tid, m_tlast} !== {64'h0123_4567_89AB_600D, 8'hA5, 1'b1, 1'b1, 1'b1}) begin
         errors++; $display("FAIL mid_new_beat: got %h exp 0123456789ab600d/a5/1/1/1", {m_tdata, m_tkeep, m_tuser, m_tid, m_tlast}); end
      @(negedge ACLK);
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL mid_no_stale: got %b exp 0", m_tvalid); end
   endtask

   initial begin
      ARESETn = 1'b1;
      flush = 1'b0; p_flush = 1'b0;
      s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tuser = 1'b0; s_tid = 1'b0; s_tlast = 1'b0;
      m_tready = 1'b0;
      p_s_tvalid = 1'b0; p_m_tready = 1'b0;
      #2 ARESETn = 1'b0;
      test_reset();
      test_stream();
      test_full();
      test_flush();
      test_random();
      test_pkt();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
